dec_frame_rx_fifo: RTL and testbench



---
 rtl/dec_frame_rx_fifo_pkg.sv | 20 ++
 rtl/dec_sync_fifo.sv | 67 ++++++
 rtl/dec_frame_rx_fifo.sv | 143 ++++++++++++++
 tb/tb_dec_frame_rx_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_frame_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// dec_frame_rx_fifo_pkg
// Shared constants and types for the decimator frame receiver.
//   DEC_DATA_W     : serial frame / word width
//   DEC_RATIO      : decimation ratio of the upstream decimator (frame period)
//   DEC_FIFO_DEPTH : default receive FIFO depth
//   rx_state_e     : receive FSM state encoding (IDLE=0, SHIFT=1)
// ---------------------------------------------------------------------------
package dec_frame_rx_fifo_pkg;

  localparam int DEC_DATA_W     = 22;
  localparam int DEC_RATIO      = 256;
  localparam int DEC_FIFO_DEPTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

endpackage : dec_frame_rx_fifo_pkg

// File: rtl/dec_sync_fifo.sv
// ---------------------------------------------------------------------------
// dec_sync_fifo
// Single-clock FIFO with the head word presented combinationally from the
// storage registers (zero while empty).
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored when full unless a pop coincides)
//   push_data  : word to write
//   pop        : remove head word (ignored when empty)
//   head_data  : word at the head, 0 when empty
//   empty/full : occupancy flags
//   level      : occupancy, one bit wider than the pointers
// ---------------------------------------------------------------------------
module dec_sync_fifo #(
  parameter int DATA_W = 22,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;

  logic w_do_pop;
  logic w_do_push;

  assign empty     = (r_level == '0);
  assign full      = (r_level == LVL_W'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign w_do_push = push & (~full | w_do_pop);
  assign level     = r_level;
  assign head_data = empty ? '0 : r_mem[r_rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + LVL_W'(w_do_push) - LVL_W'(w_do_pop);
    end
  end

  // NOTE: storage is not reset; only the pointers/level define validity and
  // head_data is forced to zero while empty, so stale contents never leak.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= push_data;
  end

endmodule : dec_sync_fifo

// File: rtl/dec_frame_rx_fifo.sv
// ---------------------------------------------------------------------------
// dec_frame_rx_fifo
// Reassembles MSB-first serial frames into signed words, flags framing
// errors and buffers words for a valid/ready consumer.
//   clk, rst      : clock (one serial bit per edge), sync active-high reset
//   data_i        : serial data
//   frame_sync    : pulse coincident with the frame MSB
//   clr_i         : clears sticky flags and the error counter
//   m_data_o      : word at FIFO head (0 when empty)
//   m_valid_o     : FIFO non-empty
//   m_ready_i     : consumer accepts head word
//   fifo_level_o  : FIFO occupancy
//   overflow_o    : sticky, a word was dropped on a full FIFO
//   frame_err_o   : sticky, frame_sync arrived mid-frame
//   err_cnt_o     : saturating framing-error count
// ---------------------------------------------------------------------------
module dec_frame_rx_fifo
  import dec_frame_rx_fifo_pkg::*;
#(
  parameter int DATA_W     = DEC_DATA_W,
  parameter int FIFO_DEPTH = DEC_FIFO_DEPTH,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_i,
  input  logic                          frame_sync,
  input  logic                          clr_i,
  output logic [DATA_W-1:0]             m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic                          frame_err_o,
  output logic [ERR_CNT_W-1:0]          err_cnt_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_e          r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [DATA_W-1:0]  r_word;
  logic               r_push;
  logic               r_overflow;
  logic               r_frame_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_early_sync;
  logic w_drop;

  assign w_early_sync = (r_state == ST_SHIFT) && frame_sync;
  assign w_pop        = ~w_empty & m_ready_i;
  // The FIFO refuses the word only when full and nothing leaves this cycle.
  assign w_drop       = r_push & w_full & ~w_pop;

  // Receive FSM. Bit 0 is captured while r_bitcnt == DATA_W-1; the word is
  // latched together with a one-cycle push strobe on that edge.
  // NOTE: every sequential assignment is non-blocking so all registers see
  // the pre-edge values of each other, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_word   <= '0;
      r_push   <= 1'b0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (frame_sync) begin
            r_shift  <= {{(DATA_W-1){1'b0}}, data_i};
            r_bitcnt <= CNT_W'(1);
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (frame_sync) begin
            // Early sync: drop the partial word, current bit becomes MSB.
            r_shift  <= {{(DATA_W-1){1'b0}}, data_i};
            r_bitcnt <= CNT_W'(1);
          end else if (r_bitcnt == CNT_W'(DATA_W - 1)) begin
            r_word   <= {r_shift[DATA_W-2:0], data_i};
            r_push   <= 1'b1;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_state  <= ST_IDLE;
          end else begin
            r_shift  <= {r_shift[DATA_W-2:0], data_i};
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags and error counter; a new event outranks a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      if (w_drop)     r_overflow <= 1'b1;
      else if (clr_i) r_overflow <= 1'b0;

      if (w_early_sync) begin
        r_frame_err <= 1'b1;
        if (clr_i)                r_err_cnt <= ERR_CNT_W'(1);
        else if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      end else if (clr_i) begin
        r_frame_err <= 1'b0;
        r_err_cnt   <= '0;
      end
    end
  end

  dec_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_push),
    .push_data (r_word),
    .pop       (w_pop),
    .head_data (m_data_o),
    .empty     (w_empty),
    .full      (w_full),
    .level     (fifo_level_o)
  );

  assign m_valid_o   = ~w_empty;
  assign overflow_o  = r_overflow;
  assign frame_err_o = r_frame_err;
  assign err_cnt_o   = r_err_cnt;

endmodule : dec_frame_rx_fifo

// File: tb/tb_dec_frame_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_dec_frame_rx_fifo
// Directed + randomized bench for dec_frame_rx_fifo. The reference model is
// a word queue plus flag/counter variables updated at transaction level.
// ---------------------------------------------------------------------------
module tb_dec_frame_rx_fifo;

  localparam int DW    = 22;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_i;
  logic          frame_sync;
  logic          clr_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [2:0]    fifo_level_o;
  logic          overflow_o;
  logic          frame_err_o;
  logic [7:0]    err_cnt_o;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  bit            m_ovf;
  bit            m_ferr;
  int            m_cnt;

  dec_frame_rx_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .data_i       (data_i),
    .frame_sync   (frame_sync),
    .clr_i        (clr_i),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .fifo_level_o (fifo_level_o),
    .overflow_o   (overflow_o),
    .frame_err_o  (frame_err_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [DW-1:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check({tag, ".valid"}, 32'(m_valid_o),    32'(exp_q.size() != 0));
    check({tag, ".level"}, 32'(fifo_level_o), 32'(exp_q.size()));
    check({tag, ".data"},  32'(m_data_o),     32'(head));
    check({tag, ".ovf"},   32'(overflow_o),   32'(m_ovf));
    check({tag, ".ferr"},  32'(frame_err_o),  32'(m_ferr));
    check({tag, ".cnt"},   32'(err_cnt_o),    32'(m_cnt));
  endtask

  // Completed word reaches the FIFO; a full FIFO drops it.
  task automatic model_push(input logic [DW-1:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else                      m_ovf = 1'b1;
  endtask

  task automatic model_err(input bit with_clr);
    m_ferr = 1'b1;
    if (with_clr)        m_cnt = 1;
    else if (m_cnt < 255) m_cnt = m_cnt + 1;
  endtask

  task automatic model_clear();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    m_cnt  = 0;
  endtask

  // Drive the first nbits of w MSB-first, frame_sync on the first bit.
  task automatic send_bits(input logic [DW-1:0] w, input int nbits, input bit with_clr);
    for (int k = 0; k < nbits; k++) begin
      data_i     = w[DW-1-k];
      frame_sync = (k == 0);
      clr_i      = with_clr && (k == 0);
      tick();
    end
    frame_sync = 1'b0;
    clr_i      = 1'b0;
    data_i     = 1'b0;
  endtask

  // Full frame plus the cycle it takes to land in the FIFO (no pop assumed).
  task automatic send_frame(input logic [DW-1:0] w);
    send_bits(w, DW, 1'b0);
    tick();
    model_push(w);
  endtask

  task automatic do_pop(input string tag);
    check_state({tag, ".pre"});
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    void'(exp_q.pop_front());
    check_state({tag, ".post"});
  endtask

  task automatic idle_noise(input int n);
    for (int k = 0; k < n; k++) begin
      data_i = 1'($urandom);
      tick();
    end
    data_i = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w;
    rst = 1'b1; data_i = 1'b1; frame_sync = 1'b0; clr_i = 1'b0; m_ready_i = 1'b0;
    model_clear();
    tick(); tick();
    rst = 1'b0;
    check_state("reset");

    // 1: single frame, valid rises one clock after bit 0
    send_bits(22'h2AAAAA, DW, 1'b0);
    check("t1.valid_at_bit0", 32'(m_valid_o), 32'd0);
    tick();
    model_push(22'h2AAAAA);
    check("t1.word", 32'(m_data_o), 32'h2AAAAA);
    check_state("t1");
    do_pop("t1.pop");

    // 2: negative values with consumer always ready, frames 256 clocks apart
    m_ready_i = 1'b1;
    send_bits(22'h3FFFFF, DW, 1'b0);
    tick();
    model_push(22'h3FFFFF);
    check("t2.minus1", 32'(m_data_o), 32'h3FFFFF);
    check_state("t2.a");
    tick();
    void'(exp_q.pop_front());
    check_state("t2.a_pop");
    idle_noise(256 - DW - 2);
    send_bits(22'h200000, DW, 1'b0);
    tick();
    model_push(22'h200000);
    check("t2.minmax", 32'(m_data_o), 32'h200000);
    check_state("t2.b");
    tick();
    void'(exp_q.pop_front());
    check_state("t2.b_pop");
    m_ready_i = 1'b0;

    // 3: early sync after 10 bits
    send_bits(22'($urandom), 10, 1'b0);
    model_err(1'b0);
    send_frame(22'h012345);
    check_state("t3");
    do_pop("t3.pop");

    // 4: overflow, then push+pop coincident while full
    for (int i = 1; i <= 5; i++) send_frame(22'(i));
    check_state("t4.full");
    send_bits(22'd6, DW, 1'b0);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(22'd6);
    check_state("t4.pushpop");
    for (int i = 0; i < 4; i++) do_pop("t4.drain");
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    model_clear();
    check_state("t4.clr");

    // 5: error saturation and clear
    frame_sync = 1'b1;
    for (int i = 0; i <= 300; i++) begin
      data_i = 1'($urandom);
      tick();
      if (i > 0) model_err(1'b0);
    end
    frame_sync = 1'b0;
    check_state("t5.sat");
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    model_clear();
    check_state("t5.clr");
    w = 22'($urandom);
    send_bits(w, DW, 1'b1);
    model_err(1'b1);
    tick();
    model_push(w);
    check_state("t5.clr_and_err");
    do_pop("t5.pop");

    // Randomized frames with random gaps and random consumption
    for (int i = 0; i < 10; i++) begin
      idle_noise(int'($urandom_range(0, 5)));
      w = 22'($urandom);
      send_frame(w);
      check_state("rnd.push");
      if ($urandom_range(0, 1) == 1) do_pop("rnd.pop");
    end

    // 6: reset mid-frame
    send_bits(22'($urandom), 12, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_clear();
    check_state("t6.reset");
    send_frame(22'h0ABCDE);
    check_state("t6.frame");
    do_pop("t6.pop");
    idle_noise(3);
    check_state("t6.end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dec_frame_rx_fifo
